mem_access_unit: RTL and testbench

Parametrised, handshaked successor to the MEM pipeline stage of the multi-cycle MIPS core. Executes LB/LBU/LH/LHU/LW/SB/SH/SW against a request/acknowledge data bus with wait states. Generates byte-lane selects, replicates store data and sign/zero-extends load data. Detects misaligned accesses and bus timeouts, stalls upstream while a transfer is outstanding, and registers all results toward write-back.

---
 rtl/mem_access_unit_pkg.sv | 45 ++++
 rtl/mem_access_unit_lane.sv | 46 ++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, reset constants, FSM encoding and access-size decode for the memory stage.
package mem_access_unit_pkg;

  localparam logic        RstEnable  = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_e;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  function automatic size_e access_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: access_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: access_size = SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             access_size = SZ_WORD;
      default:                          access_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    is_store = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_unsigned(input logic [7:0] op);
    is_unsigned = (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
    case (access_size(op))
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane mapper: byte selects, replicated store data and extended load data
// for one access, given its op and byte offset within the word.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [7:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [1:0]  blane;
  logic        hlane;
  logic [7:0]  bdat;
  logic [15:0] hdat;

  always_comb begin
    // Physical lane index counted from bits 7:0 upward.
    blane   = BIG_ENDIAN ? (2'd3 - offset_i) : offset_i;
    hlane   = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];
    bdat    = rdata_i[8*blane +: 8];
    hdat    = rdata_i[16*hlane +: 16];
    sel_o   = 4'b1111;
    wdata_o = reg2_i;
    ldata_o = rdata_i;
    case (access_size(op_i))
      SZ_BYTE: begin
        sel_o   = 4'b0001 << blane;
        wdata_o = {4{reg2_i[7:0]}};
        ldata_o = is_unsigned(op_i) ? {24'b0, bdat} : {{24{bdat[7]}}, bdat};
      end
      SZ_HALF: begin
        sel_o   = hlane ? 4'b1100 : 4'b0011;
        wdata_o = {2{reg2_i[15:0]}};
        ldata_o = is_unsigned(op_i) ? {16'b0, hdat} : {{16{hdat[15]}}, hdat};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked MEM stage: issues one bus transfer per memory op with wait-state timeout,
// flags misaligned addresses, and registers write-back results as a one-cycle pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MAX_WAIT   = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              whilo_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              out_valid,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              whilo_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              buserr_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       mwdata_q, mwdata_d;
  // Instruction parked while its transfer is outstanding.
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [4:0]        pwd_q, pwd_d;
  logic              pwreg_q, pwreg_d, pwhilo_q, pwhilo_d;
  logic [31:0]       pwdata_q, pwdata_d, phi_q, phi_d, plo_q, plo_d;
  logic              ov_q, ov_d, wreg_q, wreg_d, whilo_q, whilo_d;
  logic [4:0]        wd_q, wd_d;
  logic [31:0]       wdata_q, wdata_d, hi_q, hi_d, lo_q, lo_d;
  logic              adel_q, adel_d, ades_q, ades_d, buserr_q, buserr_d;
  logic [ADDR_W-1:0] badv_q, badv_d;

  logic [7:0]  lane_op;
  logic [1:0]  lane_off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_ldata;

  // One mapper serves both the request (live inputs) and the response (parked op).
  assign lane_op  = (state_q == BUS) ? op_q : aluop_i;
  assign lane_off = (state_q == BUS) ? paddr_q[1:0] : mem_addr_i[1:0];

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .op_i    (lane_op),
    .offset_i(lane_off),
    .reg2_i  (reg2_i),
    .rdata_i (mem_rdata_i),
    .sel_o   (lane_sel),
    .wdata_o (lane_wdata),
    .ldata_o (lane_ldata)
  );

  always_ff @(posedge clk) begin
    if (resetn == RstEnable) begin
      state_q <= IDLE;  cnt_q <= '0;
      req_q <= 1'b0;  we_q <= 1'b0;  maddr_q <= '0;  sel_q <= 4'b0;  mwdata_q <= ZeroWord;
      op_q <= 8'h00;  paddr_q <= '0;  pwd_q <= NOPRegAddr;  pwreg_q <= 1'b0;
      pwhilo_q <= 1'b0;  pwdata_q <= ZeroWord;  phi_q <= ZeroWord;  plo_q <= ZeroWord;
      ov_q <= 1'b0;  wd_q <= NOPRegAddr;  wreg_q <= 1'b0;  wdata_q <= ZeroWord;
      whilo_q <= 1'b0;  hi_q <= ZeroWord;  lo_q <= ZeroWord;
      adel_q <= 1'b0;  ades_q <= 1'b0;  buserr_q <= 1'b0;  badv_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      req_q <= req_d;  we_q <= we_d;  maddr_q <= maddr_d;  sel_q <= sel_d;  mwdata_q <= mwdata_d;
      op_q <= op_d;  paddr_q <= paddr_d;  pwd_q <= pwd_d;  pwreg_q <= pwreg_d;
      pwhilo_q <= pwhilo_d;  pwdata_q <= pwdata_d;  phi_q <= phi_d;  plo_q <= plo_d;
      ov_q <= ov_d;  wd_q <= wd_d;  wreg_q <= wreg_d;  wdata_q <= wdata_d;
      whilo_q <= whilo_d;  hi_q <= hi_d;  lo_q <= lo_d;
      adel_q <= adel_d;  ades_q <= ades_d;  buserr_q <= buserr_d;  badv_q <= badv_d;
    end
  end

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;
    req_d = req_q;  we_d = we_q;  maddr_d = maddr_q;  sel_d = sel_q;  mwdata_d = mwdata_q;
    op_d = op_q;  paddr_d = paddr_q;  pwd_d = pwd_q;  pwreg_d = pwreg_q;
    pwhilo_d = pwhilo_q;  pwdata_d = pwdata_q;  phi_d = phi_q;  plo_d = plo_q;
    ov_d = 1'b0;  wd_d = wd_q;  wreg_d = wreg_q;  wdata_d = wdata_q;
    whilo_d = whilo_q;  hi_d = hi_q;  lo_d = lo_q;
    adel_d = 1'b0;  ades_d = 1'b0;  buserr_d = 1'b0;  badv_d = badv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (access_size(aluop_i) == SZ_NONE) begin
            ov_d = 1'b1;  wd_d = wd_i;  wreg_d = wreg_i;  wdata_d = wdata_i;
            whilo_d = whilo_i;  hi_d = hi_i;  lo_d = lo_i;
          end else if (misaligned(aluop_i, mem_addr_i[1:0])) begin
            ov_d = 1'b1;  wd_d = wd_i;  wreg_d = 1'b0;  wdata_d = wdata_i;
            whilo_d = 1'b0;  hi_d = hi_i;  lo_d = lo_i;
            adel_d = ~is_store(aluop_i);
            ades_d = is_store(aluop_i);
            badv_d = mem_addr_i;
          end else begin
            state_d  = BUS;  cnt_d = '0;
            req_d    = 1'b1;  we_d = is_store(aluop_i);
            maddr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
            sel_d    = lane_sel;  mwdata_d = lane_wdata;
            op_d = aluop_i;  paddr_d = mem_addr_i;  pwd_d = wd_i;  pwreg_d = wreg_i;
            pwhilo_d = whilo_i;  pwdata_d = wdata_i;  phi_d = hi_i;  plo_d = lo_i;
          end
        end
      end
      BUS: begin
        if (mem_ack_i || cnt_q == CNT_LAST) begin
          state_d = IDLE;  cnt_d = '0;
          req_d = 1'b0;  we_d = 1'b0;  maddr_d = '0;  sel_d = 4'b0;  mwdata_d = ZeroWord;
          ov_d = 1'b1;  wd_d = pwd_q;  hi_d = phi_q;  lo_d = plo_q;
          if (mem_ack_i) begin
            wreg_d  = pwreg_q;  whilo_d = pwhilo_q;
            wdata_d = is_store(op_q) ? pwdata_q : lane_ldata;
          end else begin
            wreg_d = 1'b0;  whilo_d = 1'b0;  wdata_d = pwdata_q;
            buserr_d = 1'b1;  badv_d = paddr_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = maddr_q;
  assign mem_sel_o   = sel_q;
  assign mem_wdata_o = mwdata_q;
  assign out_valid   = ov_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign whilo_o     = whilo_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign adel_o      = adel_q;
  assign ades_o      = ades_q;
  assign buserr_o    = buserr_q;
  assign badvaddr_o  = badv_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: directed ops push expected results; a bus model and a monitor check the DUT.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, in_ready;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_sel_o;
  logic        out_valid, wreg_o, whilo_o, adel_o, ades_o, buserr_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, hi_o, lo_o, badvaddr_o;

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(4), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .out_valid(out_valid), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .adel_o(adel_o), .ades_o(ades_o), .buserr_o(buserr_o),
    .badvaddr_o(badvaddr_o)
  );

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        adel;
    logic        ades;
    logic        buserr;
    logic [31:0] badvaddr;
  } res_t;

  typedef struct {
    int          wait_cyc;
    int          exp_cycles;
    logic        late;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        chk_wdata;
    logic [31:0] wdata;
  } bus_t;

  res_t exp_q[$];
  bus_t bus_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                              input logic adel, input logic ades, input logic buserr,
                              input logic [31:0] badv);
    res_t r;
    r.wd = wd;  r.wreg = wreg;  r.wdata = wdata;  r.whilo = whilo;  r.hi = hi;  r.lo = lo;
    r.adel = adel;  r.ades = ades;  r.buserr = buserr;  r.badvaddr = badv;
    return r;
  endfunction

  task automatic bus_exp(input int wait_cyc, input int exp_cycles, input logic late,
                         input logic [31:0] rdata, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic chk_wdata, input logic [31:0] wdata);
    bus_t b;
    b.wait_cyc = wait_cyc;  b.exp_cycles = exp_cycles;  b.late = late;  b.rdata = rdata;
    b.we = we;  b.addr = addr;  b.sel = sel;  b.chk_wdata = chk_wdata;  b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;  failures++;
      $display("FAIL issue_wait: in_ready still %b after 50 cycles, required 1", in_ready);
    end
    aluop_i = op;  mem_addr_i = addr;  reg2_i = reg2;  wd_i = wd;  wreg_i = wreg;
    wdata_i = wdata;  whilo_i = whilo;  hi_i = hi;  lo_i = lo;  in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expected result per out_valid pulse.
  initial begin : monitor
    res_t e, got;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        got = {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, adel_o, ades_o, buserr_o, badvaddr_o};
        if (exp_q.size() == 0) begin
          checks++;  failures++;
          $display("FAIL unexpected_out_valid: got result %0h, required no pulse", got);
        end else begin
          e = exp_q.pop_front();
          if (e.adel | e.ades | e.buserr) begin
            got.wd = '0;  got.wdata = '0;  got.hi = '0;  got.lo = '0;
            e.wd   = '0;  e.wdata   = '0;  e.hi   = '0;  e.lo   = '0;
          end else begin
            got.badvaddr = '0;  e.badvaddr = '0;
          end
          chk("result", got, e);
        end
      end else begin
        chk("flags_without_valid", {adel_o, ades_o, buserr_o}, 3'b000);
      end
      if (mem_req_o) chk("in_ready_during_bus", in_ready, 1'b0);
    end
  end

  // Bus slave: acks after the scripted number of wait cycles and checks request stability.
  initial begin : bus_model
    bus_t b;
    int   hi_cnt;
    logic busy;
    busy = 1'b0;  hi_cnt = 0;
    mem_ack_i = 1'b0;  mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;  mem_rdata_i = 32'h0;
      if (!busy && mem_req_o) begin
        if (bus_q.size() == 0) begin
          checks++;  failures++;
          $display("FAIL unexpected_req: got req addr %0h, required no request", mem_addr_o);
        end else begin
          b = bus_q.pop_front();
          busy = 1'b1;  hi_cnt = 0;
        end
      end
      if (busy) begin
        if (mem_req_o) begin
          hi_cnt++;
          chk("bus_addr", mem_addr_o, b.addr);
          chk("bus_we", mem_we_o, b.we);
          chk("bus_sel", mem_sel_o, b.sel);
          if (b.chk_wdata) chk("bus_wdata", mem_wdata_o, b.wdata);
          if (hi_cnt == b.wait_cyc + 1) begin
            mem_ack_i = 1'b1;  mem_rdata_i = b.rdata;
          end
        end else begin
          chk("req_cycles", hi_cnt, b.exp_cycles);
          if (b.late) begin
            mem_ack_i = 1'b1;  mem_rdata_i = 32'hFFFF_FFFF;
          end
          busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    resetn = 1'b0;  in_valid = 1'b0;  aluop_i = 8'h0;  mem_addr_i = 32'h0;  reg2_i = 32'h0;
    wd_i = 5'd0;  wreg_i = 1'b0;  wdata_i = 32'h0;  whilo_i = 1'b0;  hi_i = 32'h0;  lo_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_bus_outputs", {out_valid, mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o}, '0);
    chk("reset_result_outputs",
        {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, adel_o, ades_o, buserr_o, badvaddr_o}, '0);
    @(posedge clk); #1;

    // LW with 3 wait cycles: ack lands in the last cycle before timeout and must win.
    bus_exp(3, 4, 1'b0, 32'h8899_AABB, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd3, 1'b1, 32'h8899_AABB, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Byte/half loads, big-endian lanes, sign and zero extension.
    bus_exp(0, 1, 1'b0, 32'h1122_3380, 1'b0, 32'h100, 4'b0001, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd4, 1'b1, 32'hFFFF_FF80, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LB_OP, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus_exp(0, 1, 1'b0, 32'h1122_3380, 1'b0, 32'h100, 4'b0001, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd5, 1'b1, 32'h0000_0080, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LBU_OP, 32'h103, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus_exp(0, 1, 1'b0, 32'h7F00_0000, 1'b0, 32'h100, 4'b1000, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd6, 1'b1, 32'h0000_007F, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LB_OP, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus_exp(2, 3, 1'b0, 32'h1122_8001, 1'b0, 32'h100, 4'b0011, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd7, 1'b1, 32'hFFFF_8001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LH_OP, 32'h102, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus_exp(0, 1, 1'b0, 32'h8001_1234, 1'b0, 32'h100, 4'b1100, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd8, 1'b1, 32'h0000_8001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LHU_OP, 32'h100, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Stores: lane selects and data replication; wreg passes through as 0.
    bus_exp(1, 2, 1'b0, 32'h0, 1'b1, 32'h100, 4'b0011, 1'b1, 32'hBEEF_BEEF);
    exp_q.push_back(mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_SH_OP, 32'h102, 32'h0000_BEEF, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    bus_exp(0, 1, 1'b0, 32'h0, 1'b1, 32'h100, 4'b0100, 1'b1, 32'hABAB_ABAB);
    exp_q.push_back(mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_SB_OP, 32'h101, 32'h1234_56AB, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    bus_exp(0, 1, 1'b0, 32'h0, 1'b1, 32'h104, 4'b1111, 1'b1, 32'hDEAD_BEEF);
    exp_q.push_back(mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_SW_OP, 32'h104, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Misaligned accesses: no bus request, error flag, wreg/whilo forced low.
    exp_q.push_back(mk(5'd9, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h101));
    issue(EXE_LW_OP, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0);
    exp_q.push_back(mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h101));
    issue(EXE_SH_OP, 32'h101, 32'h1234, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(mk(5'd10, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h103));
    issue(EXE_LH_OP, 32'h103, 32'h0, 5'd10, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Store never acked: times out after MAX_WAIT cycles.
    bus_exp(99, 4, 1'b0, 32'h0, 1'b1, 32'h200, 4'b1111, 1'b1, 32'hCAFE_F00D);
    exp_q.push_back(mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200));
    issue(EXE_SW_OP, 32'h200, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_out_valid", out_valid, 1'b1);
      chk("ready_after_timeout", in_ready, 1'b1);
    end
    @(posedge clk); #1;

    // Back-to-back non-memory ops, including an unknown opcode.
    begin
      logic [7:0]  ops [4];
      logic [31:0] vals[4];
      ops[0] = 8'h25;  ops[1] = 8'h21;  ops[2] = 8'h1A;  ops[3] = 8'hFF;
      vals[0] = 32'h1111_1111;  vals[1] = 32'h2222_0000;  vals[2] = 32'h0;  vals[3] = 32'h8000_0001;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(mk(5'(i + 11), i != 2, vals[i], i == 2, 32'hAAAA_0000 + i, 32'h5555_0000 + i,
                           1'b0, 1'b0, 1'b0, 32'h0));
        issue(ops[i], 32'h0, 32'h0, 5'(i + 11), i != 2, vals[i], i == 2,
              32'hAAAA_0000 + i, 32'h5555_0000 + i);
        chk("b2b_out_valid", out_valid, 1'b1);
      end
    end

    // Reset while the bus is busy; the late ack must not produce a result.
    bus_exp(99, 1, 1'b1, 32'h0, 1'b0, 32'h300, 4'b1111, 1'b0, 32'h0);
    issue(EXE_LW_OP, 32'h300, 32'h0, 5'd20, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midbus_reset_bus", {out_valid, mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o}, '0);
      chk("midbus_reset_result",
          {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, adel_o, ades_o, buserr_o, badvaddr_o}, '0);
      chk("midbus_reset_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1;

    // Unit still works after the mid-transfer reset.
    bus_exp(0, 1, 1'b0, 32'h00C3_0000, 1'b0, 32'h100, 4'b0100, 1'b0, 32'h0);
    exp_q.push_back(mk(5'd21, 1'b1, 32'hFFFF_FFC3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    issue(EXE_LB_OP, 32'h101, 32'h0, 5'd21, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("bus_script_drained", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
